// File: rtl/flashrom_pkg.sv
// Shared definitions for the FlashROM read-port initiator: array geometry, FSM states
// and the byte-count clamp applied to incoming transfer requests.
package flashrom_pkg;

    localparam int FROM_AW    = 7;
    localparam int FROM_DW    = 8;
    localparam int FROM_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_e;

    // Requests longer than the whole array are treated as a full-array read.
    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        logic [7:0] res;
        if (len > 8'(FROM_DEPTH)) begin
            res = 8'(FROM_DEPTH);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/flashrom_reader.sv
// FlashROM read initiator: walks a byte range, packs byte pairs little-endian into 16-bit
// words on a valid/ready stream. Define FLASHROM_READER_CHECKSUM_EN to add CHECKSUM.
module flashrom_reader
    import flashrom_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [FROM_AW-1:0] START_ADDR,
    input  logic [7:0]         LEN,
    output logic               BUSY,
    output logic               DONE,
    output logic [15:0]        DATA,
    output logic               VALID,
    input  logic               READY,
    output logic [FROM_AW-1:0] FROM_ADDR,
    input  logic [FROM_DW-1:0] FROM_DOUT
`ifdef FLASHROM_READER_CHECKSUM_EN
    ,
    output logic [7:0]         CHECKSUM
`endif
);

    localparam logic [2:0] RL_W = 3'(READ_LATENCY);

    state_e             state_q, state_d;
    logic [FROM_AW-1:0] addr_q, addr_d;
    logic [7:0]         rem_q, rem_d;
    logic [2:0]         wait_q, wait_d;
    logic               hi_q, hi_d;
    logic [15:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept_s;
    logic               capture_s;
    logic [7:0]         len_s;

    assign len_s     = clamp_len(LEN);
    // BUSY stays high through the DONE cycle, so it alone gates new requests.
    assign accept_s  = (state_q == IDLE) && START && !busy_q;
    assign capture_s = (state_q == FETCH) && (wait_q == 3'd0);

    // Next-state and datapath updates for the transfer FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        hi_d    = hi_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d = START_ADDR;
                    rem_d  = len_s;
                    wait_d = RL_W;
                    hi_d   = 1'b0;
                    data_d = 16'h0000;
                    if (len_s == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (capture_s) begin
                    rem_d  = rem_q - 8'd1;
                    wait_d = RL_W;
                    if (hi_q) begin
                        data_d = {FROM_DOUT, data_q[7:0]};
                    end else begin
                        data_d = {8'h00, FROM_DOUT};
                    end
                    // The last byte's address is kept on the pins after the transfer.
                    if (rem_q > 8'd1) begin
                        addr_d = addr_q + 7'd1;
                    end else begin
                        addr_d = addr_q;
                    end
                    if (hi_q || (rem_q == 8'd1)) begin
                        hi_d    = 1'b0;
                        state_d = PRESENT;
                    end else begin
                        hi_d    = 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            PRESENT: begin
                if (valid_q && READY) begin
                    wait_d = RL_W;
                    if (rem_q != 8'd0) begin
                        state_d = FETCH;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE) || done_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= 8'd0;
            wait_q  <= 3'd0;
            hi_q    <= 1'b0;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FROM_ADDR = addr_q;

`ifdef FLASHROM_READER_CHECKSUM_EN
    logic [7:0] cksum_q, cksum_d;

    // Running modulo-256 sum of the bytes actually read; the pad byte never enters it.
    always_comb begin
        cksum_d = cksum_q;
        if (accept_s) begin
            cksum_d = 8'h00;
        end else if (capture_s) begin
            cksum_d = cksum_q + FROM_DOUT;
        end else begin
            cksum_d = cksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cksum_q <= 8'h00;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign CHECKSUM = cksum_q;
`endif

endmodule

// File: tb/tb_flashrom_reader.sv
// Randomized self-checking bench for flashrom_reader against a word-list reference model.
module tb_flashrom_reader;

    localparam int RL = 2;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [6:0]  START_ADDR;
    logic [7:0]  LEN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] DATA;
    logic        VALID;
    logic        READY;
    logic [6:0]  FROM_ADDR;
    logic [7:0]  FROM_DOUT;
`ifdef FLASHROM_READER_CHECKSUM_EN
    logic [7:0]  CHECKSUM;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    flashrom_reader #(.READ_LATENCY(RL)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .DATA(DATA), .VALID(VALID), .READY(READY),
        .FROM_ADDR(FROM_ADDR), .FROM_DOUT(FROM_DOUT)
`ifdef FLASHROM_READER_CHECKSUM_EN
        , .CHECKSUM(CHECKSUM)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // FROM model: DOUT = ADDR ^ 0xA5 through an RL-deep register pipeline.
    logic [7:0] pipe [0:3];
    always @(posedge CLK) begin
        pipe[0] <= FROM_ADDR ^ 8'hA5;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign FROM_DOUT = pipe[RL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [6:0] a, input logic [7:0] l, input int rdy_pct,
                            input bit stall_mode, input bit chk_lat, input int inject_cyc);
        logic [15:0] exp_q[$];
        logic [7:0]  lo, hi, sum;
        logic [15:0] prev_data;
        logic [6:0]  prev_addr;
        int n, cyc, done_n, done_cyc, first_valid;
        bit busy_bad, stall_prev, idle_bad;
        n = (l > 8'd128) ? 128 : int'(l);
        sum = 8'h00;
        for (int i = 0; i < n; i += 2) begin
            lo = 8'(((int'(a) + i) % 128) ^ 'hA5);
            hi = (i + 1 < n) ? 8'(((int'(a) + i + 1) % 128) ^ 'hA5) : 8'h00;
            sum = sum + lo + hi;
            exp_q.push_back({hi, lo});
        end
        @(negedge CLK);
        START = 1'b1; START_ADDR = a; LEN = l;
        @(posedge CLK); #1;
        cyc = 0; done_n = 0; done_cyc = -1; first_valid = -1;
        busy_bad = 1'b0; stall_prev = 1'b0; prev_data = 16'h0; prev_addr = 7'h0;
        while (done_n == 0 && cyc < 5000) begin
            cyc++;
            if (cyc == inject_cyc) begin
                START = 1'b1; START_ADDR = 7'($urandom); LEN = 8'($urandom_range(1, 20));
            end else begin
                START = 1'b0;
            end
            if (stall_mode) READY = !(cyc >= 2*(RL+1)+1 && cyc <= 2*(RL+1)+5);
            else            READY = ($urandom_range(99) < rdy_pct);
            @(negedge CLK);
            if (!BUSY) busy_bad = 1'b1;
            if (VALID && first_valid < 0) first_valid = cyc;
            if (stall_prev) begin
                check("stall_valid", 32'(VALID), 32'd1);
                check("stall_data", 32'(DATA), 32'(prev_data));
                check("stall_addr", 32'(FROM_ADDR), 32'(prev_addr));
            end
            if (VALID && READY) begin
                if (exp_q.size() == 0) check("extra_word", 32'(DATA), 32'hFFFF_FFFF);
                else check("data", 32'(DATA), 32'(exp_q.pop_front()));
            end
            if (DONE) begin
                done_n++;
                done_cyc = cyc;
`ifdef FLASHROM_READER_CHECKSUM_EN
                check("checksum", 32'(CHECKSUM), 32'(sum));
`endif
            end
            stall_prev = VALID && !READY;
            prev_data  = DATA;
            prev_addr  = FROM_ADDR;
            @(posedge CLK); #1;
        end
        START = 1'b0;
        check("done_seen", 32'(done_n), 32'd1);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("busy_during", 32'(busy_bad), 32'd0);
        if (chk_lat && n >= 2) check("first_valid_lat", 32'(first_valid), 32'(2*(RL+1)+1));
        if (n == 0) begin
            check("len0_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
            check("len0_done_cyc", 32'(done_cyc), 32'd2);
        end
        idle_bad = 1'b0;
        READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (BUSY || DONE || VALID) idle_bad = 1'b1;
            @(posedge CLK); #1;
        end
        check("idle_after", 32'(idle_bad), 32'd0);
    endtask

    initial begin
        logic bad_done;
        RST_N = 1'b0; START = 1'b0; START_ADDR = 7'h0; LEN = 8'h0; READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", {BUSY, DONE, VALID, DATA, FROM_ADDR}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_xfer(7'h10, 8'd4, 100, 1'b0, 1'b1, 0);
        run_xfer(7'h7E, 8'd4, 100, 1'b0, 1'b1, 3);
        run_xfer(7'h00, 8'd3, 100, 1'b0, 1'b1, 0);
        run_xfer(7'h30, 8'd6, 100, 1'b1, 1'b1, 0);
        run_xfer(7'h55, 8'd0, 100, 1'b0, 1'b0, 2);
        run_xfer(7'h05, 8'd200, 70, 1'b0, 1'b0, 5);
        run_xfer(7'h7F, 8'd1, 100, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a transfer.
        @(negedge CLK);
        START = 1'b1; START_ADDR = 7'h20; LEN = 8'd10; READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_outputs", {BUSY, DONE, VALID, DATA, FROM_ADDR}, 32'd0);
        bad_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || BUSY) bad_done = 1'b1;
        end
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || BUSY || VALID) bad_done = 1'b1;
        end
        check("rst_no_done", 32'(bad_done), 32'd0);
        run_xfer(7'h40, 8'd5, 100, 1'b0, 1'b1, 0);

        for (int t = 0; t < 25; t++) begin
            run_xfer(7'($urandom), 8'($urandom_range(0, 140)), int'($urandom_range(20, 100)),
                     1'b0, 1'b0, int'($urandom_range(0, 12)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
